cache_controller: RTL and testbench

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_controller.sv | 101 ++++++++++
 tb/tb_cache_controller.sv | 112 +++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// cache_controller: 2-way set-associative write-through, no-write-allocate cache (64 sets, 1 word/line, 24-bit tag).
// Ports:
//   clk, rst (async, active-high)
//   rd_en, wr_en, address[31:0], write_data[31:0]  - MEM-stage request (level, held until ready)
//   read_data[31:0], ready                        - load result / pipeline advance
//   sram_rd_en, sram_wr_en, sram_address[31:0], sram_write_data[31:0] - SRAM controller request
//   sram_read_data[31:0], sram_ready               - SRAM controller response
module cache_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_write_data,
  input  logic [31:0] sram_read_data,
  input  logic        sram_ready
);
  typedef enum logic [1:0] {IDLE, RD_MISS, WRITE} state_t;
  state_t state, next;
  logic [63:0] valid0, valid1, lru;
  logic [23:0] tag0 [64];
  logic [23:0] tag1 [64];
  logic [31:0] data0 [64];
  logic [31:0] data1 [64];
  logic [5:0] idx;
  logic [23:0] tag;
  logic hit0, hit1, hit, victim1, fill, wr_upd, touch, used1;
  logic unused_bits;
  assign idx = address[7:2];
  assign tag = address[31:8];
  assign unused_bits = ^address[1:0];
  assign sram_address = address;
  assign sram_write_data = write_data;
  // way0 wins when both ways match
  assign hit0 = valid0[idx] && tag0[idx] == tag;
  assign hit1 = !hit0 && valid1[idx] && tag1[idx] == tag;
  assign hit = hit0 | hit1;
  // first invalid way, else the LRU way
  assign victim1 = !valid0[idx] ? 1'b0 : !valid1[idx] ? 1'b1 : lru[idx];
  // a request dropped before completion finishes the SRAM access but is not cached
  assign fill = state == RD_MISS && sram_ready && rd_en && !wr_en;
  assign wr_upd = state == WRITE && sram_ready && wr_en && hit;
  assign touch = fill || wr_upd || (state == IDLE && rd_en && !wr_en && hit);
  assign used1 = fill ? victim1 : hit1;
  always_comb begin
    next = state;
    ready = 1'b0;
    sram_rd_en = 1'b0;
    sram_wr_en = 1'b0;
    read_data = hit1 ? data1[idx] : data0[idx];
    case (state)
      IDLE: begin
        ready = !(wr_en || (rd_en && !hit));
        next = wr_en ? WRITE : (rd_en && !hit) ? RD_MISS : IDLE;
      end
      RD_MISS: begin
        sram_rd_en = 1'b1;
        ready = sram_ready;
        read_data = sram_read_data;
        next = sram_ready ? IDLE : RD_MISS;
      end
      WRITE: begin
        sram_wr_en = 1'b1;
        ready = sram_ready;
        next = sram_ready ? IDLE : WRITE;
      end
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      valid0 <= '0;
      valid1 <= '0;
      lru <= '0;
    end else begin
      state <= next;
      if (fill && victim1) valid1[idx] <= 1'b1;
      if (fill && !victim1) valid0[idx] <= 1'b1;
      if (touch) lru[idx] <= !used1;
    end
  end
  always_ff @(posedge clk) begin
    if (fill && victim1) begin
      tag1[idx] <= tag;
      data1[idx] <= sram_read_data;
    end
    if (fill && !victim1) begin
      tag0[idx] <= tag;
      data0[idx] <= sram_read_data;
    end
    if (wr_upd && hit1) data1[idx] <= write_data;
    if (wr_upd && hit0) data0[idx] <= write_data;
  end
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: scoreboard bench for cache_controller with a bench-driven SRAM responder.
module tb_cache_controller;
  logic clk = 0, rst = 1, rd_en = 0, wr_en = 0, ready, sram_rd_en, sram_wr_en, sram_ready = 0;
  logic [31:0] address = 0, write_data = 0, read_data, sram_address, sram_write_data, sram_read_data = 0;
  logic [31:0] rd_q [$];
  logic [31:0] wr_q [$];
  int n_chk = 0, n_pass = 0;
  cache_controller dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address), .write_data(write_data),
    .read_data(read_data), .ready(ready), .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en),
    .sram_address(sram_address), .sram_write_data(sram_write_data),
    .sram_read_data(sram_read_data), .sram_ready(sram_ready)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  // Request held until ready; the SRAM answers after lat cycles with mem.
  task automatic xfer(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] mem, input int lat, input logic exp_hit);
    int waits;
    logic saw_rd = 0, saw_wr = 0;
    @(negedge clk);
    rd_en = rd; wr_en = wr; address = a; write_data = d;
    if (wr) wr_q.push_back(d);
    else rd_q.push_back(mem);
    for (waits = 0; waits < 100; waits++) begin
      if (waits > 0) begin
        @(negedge clk);
        sram_ready = (waits == lat);
        sram_read_data = (waits == lat) ? mem : 32'h0BAD_0BAD;
      end
      #1;
      saw_rd |= sram_rd_en;
      saw_wr |= sram_wr_en;
      if (sram_rd_en && sram_wr_en) check("both_sram_en", 1, 0);
      if (ready) break;
    end
    check(wr ? "wr_latency" : "rd_latency", waits, (!wr && exp_hit) ? 0 : lat);
    check("sram_rd_seen", saw_rd, !wr && !exp_hit);
    check("sram_wr_seen", saw_wr, wr);
    if (wr) begin
      check("sram_addr", sram_address, a);
      check("sram_wdata", sram_write_data, wr_q.pop_front());
    end else check("read_data", read_data, rd_q.pop_front());
    @(negedge clk);
    rd_en = 0; wr_en = 0; sram_ready = 0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", ready, 1);
    check("rst_sram_rd", sram_rd_en, 0);
    check("rst_sram_wr", sram_wr_en, 0);
    rst = 0;
    @(negedge clk);
    sram_ready = 1;
    #1;
    check("idle_sram_ready_ready", ready, 1);
    check("idle_sram_ready_rd", sram_rd_en, 0);
    check("idle_sram_ready_wr", sram_wr_en, 0);
    @(negedge clk);
    sram_ready = 0;
    xfer(1, 0, 32'h0000_0404, 0, 32'hDEAD_BEEF, 5, 0);
    xfer(1, 0, 32'h0000_0404, 0, 32'hDEAD_BEEF, 0, 1);
    xfer(1, 0, 32'h0000_0504, 0, 32'h0000_5555, 2, 0);
    xfer(1, 0, 32'h0000_0604, 0, 32'h0000_6666, 3, 0);
    xfer(1, 0, 32'h0000_0504, 0, 32'h0000_5555, 0, 1);
    xfer(1, 0, 32'h0000_0604, 0, 32'h0000_6666, 0, 1);
    xfer(1, 0, 32'h0000_0404, 0, 32'h0000_4444, 3, 0);
    xfer(1, 0, 32'h0000_0404, 0, 32'h0000_4444, 0, 1);
    xfer(1, 0, 32'h0000_0504, 0, 32'h0000_5151, 1, 0);
    xfer(0, 1, 32'h0000_0404, 32'h1234_5678, 0, 4, 0);
    xfer(1, 0, 32'h0000_0404, 0, 32'h1234_5678, 0, 1);
    xfer(0, 1, 32'h0000_0808, 32'hAAAA_0808, 0, 2, 0);
    xfer(1, 0, 32'h0000_0808, 0, 32'hBBBB_0808, 2, 0);
    xfer(1, 1, 32'h0000_0404, 32'hCAFE_F00D, 0, 3, 0);
    xfer(1, 0, 32'h0000_0404, 0, 32'hCAFE_F00D, 0, 1);
    @(negedge clk);
    rd_en = 1; address = 32'h0000_0C04;
    @(negedge clk);
    rd_en = 0;
    @(negedge clk);
    sram_ready = 1; sram_read_data = 32'h0000_0C0C;
    #1;
    check("drop_rd_still_active", sram_rd_en, 1);
    check("drop_rd_ready", ready, 1);
    @(negedge clk);
    sram_ready = 0;
    #1;
    check("drop_rd_idle", sram_rd_en, 0);
    xfer(1, 0, 32'h0000_0C04, 0, 32'h0000_0CCC, 2, 0);
    @(negedge clk);
    rd_en = 1; address = 32'h0000_0A04;
    repeat (2) @(negedge clk);
    #1;
    check("pre_rst_sram_rd", sram_rd_en, 1);
    #2 rst = 1;
    #1;
    check("rst_abort_sram_rd", sram_rd_en, 0);
    @(negedge clk);
    rd_en = 0;
    @(negedge clk);
    rst = 0;
    xfer(1, 0, 32'h0000_0404, 0, 32'h0000_0404, 2, 0);
    xfer(1, 0, 32'h0000_0A04, 0, 32'h0000_0A0A, 2, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
